// File: rtl/cflog_wr_arbiter.sv
// CF-Log write-port arbiter: serialises marker, live and cached entries into two 16-bit beats
// and maintains the log write pointer with wrap/overflow and a small live-entry skid queue.
module cflog_wr_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LIVE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              live_req,
    input  logic [DATA_W-1:0] live_src,
    input  logic [DATA_W-1:0] live_dest,
    input  logic              cache_req,
    input  logic [DATA_W-1:0] cache_src,
    input  logic [DATA_W-1:0] cache_dest,
    output logic              cache_ack,
    input  logic              mark_req,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [DATA_W-1:0] mark_upper,
    input  logic [DATA_W-1:0] mark_lower,
    input  logic [ADDR_W-1:0] log_min,
    input  logic [ADDR_W-1:0] log_max,
    output logic              log_wen,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_wdata,
    output logic [ADDR_W-1:0] log_ptr,
    output logic              busy,
    output logic              overflow,
    output logic              live_drop
);

    localparam int unsigned PtrW = (LIVE_DEPTH > 1) ? $clog2(LIVE_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StInit, StIdle, StWrSrc, StWrDst} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ent_src_q, ent_src_d, ent_dst_q, ent_dst_d;
    logic [ADDR_W-1:0]   ent_base_q, ent_base_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ovf_q, ovf_d, drop_q, drop_d;
    logic                mk_pend_q, mk_pend_d;
    logic [ADDR_W-1:0]   mk_addr_q, mk_addr_d;
    logic [DATA_W-1:0]   mk_upper_q, mk_upper_d, mk_lower_q, mk_lower_d;
    logic [DATA_W-1:0]   q_src_q [LIVE_DEPTH];
    logic [DATA_W-1:0]   q_src_d [LIVE_DEPTH];
    logic [DATA_W-1:0]   q_dst_q [LIVE_DEPTH];
    logic [DATA_W-1:0]   q_dst_d [LIVE_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                arb_en, grant_mark, grant_live, grant_cache;
    logic                q_empty, q_full, bypass, push, pop, accept, wrap;
    logic [ADDR_W:0]     nxt_full, end_full;
    logic [ADDR_W-1:0]   ptr_upd, cur_ptr;
    logic                unused_mark_lsb;

    assign unused_mark_lsb = mark_addr[0];
    assign q_empty = (cnt_q == '0);
    assign q_full  = (cnt_q == CntW'(LIVE_DEPTH));

    // Pointer that results from completing the entry currently in flight.
    assign nxt_full = {1'b0, ent_base_q} + (ADDR_W + 1)'(4);
    assign end_full = {1'b0, nxt_full[ADDR_W-1:0]} + (ADDR_W + 1)'(3);
    assign wrap     = nxt_full[ADDR_W] | (end_full > {1'b0, log_max});
    assign ptr_upd  = wrap ? log_min : nxt_full[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        ent_src_d   = ent_src_q;
        ent_dst_d   = ent_dst_q;
        ent_base_d  = ent_base_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        mk_pend_d   = mk_pend_q;
        mk_addr_d   = mk_addr_q;
        mk_upper_d  = mk_upper_q;
        mk_lower_d  = mk_lower_q;
        q_src_d     = q_src_q;
        q_dst_d     = q_dst_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        arb_en      = 1'b0;
        cur_ptr     = ptr_q;
        grant_mark  = 1'b0;
        grant_live  = 1'b0;
        grant_cache = 1'b0;
        cache_ack   = 1'b0;
        log_wen     = 1'b0;
        log_addr    = '0;
        log_wdata   = '0;

        case (state_q)
            StInit: begin
                ptr_d   = log_min;
                state_d = StIdle;
            end
            StIdle: arb_en = 1'b1;
            StWrSrc: begin
                log_wen   = 1'b1;
                log_addr  = ent_base_q;
                log_wdata = ent_src_q;
                state_d   = StWrDst;
            end
            StWrDst: begin
                log_wen   = 1'b1;
                log_addr  = ent_base_q + ADDR_W'(2);
                log_wdata = ent_dst_q;
                ptr_d     = ptr_upd;
                ovf_d     = ovf_q | wrap;
                cur_ptr   = ptr_upd;
                arb_en    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StInit;
        endcase

        // Same-cycle requests bypass their holding registers so a grant in IDLE costs no cycle.
        if (arb_en) begin
            if (mk_pend_q || mark_req) begin
                grant_mark = 1'b1;
                ent_src_d  = mark_req ? mark_upper : mk_upper_q;
                ent_dst_d  = mark_req ? mark_lower : mk_lower_q;
                ent_base_d = mark_req ? {mark_addr[ADDR_W-1:1], 1'b0} : mk_addr_q;
                state_d    = StWrSrc;
            end else if (!q_empty || live_req) begin
                grant_live = 1'b1;
                ent_src_d  = q_empty ? live_src : q_src_q[rd_ptr_q];
                ent_dst_d  = q_empty ? live_dest : q_dst_q[rd_ptr_q];
                ent_base_d = cur_ptr;
                state_d    = StWrSrc;
            end else if (cache_req) begin
                grant_cache = 1'b1;
                cache_ack   = 1'b1;
                ent_src_d   = cache_src;
                ent_dst_d   = cache_dest;
                ent_base_d  = cur_ptr;
                state_d     = StWrSrc;
            end
        end

        if (mark_req) begin
            mk_pend_d  = 1'b1;
            mk_addr_d  = {mark_addr[ADDR_W-1:1], 1'b0};
            mk_upper_d = mark_upper;
            mk_lower_d = mark_lower;
        end
        if (grant_mark) mk_pend_d = 1'b0;

        bypass = grant_live & q_empty;
        pop    = grant_live & ~q_empty;
        push   = live_req & ~bypass;
        accept = push & (~q_full | pop);
        if (push && q_full && !pop) drop_d = 1'b1;
        if (accept) begin
            q_src_d[wr_ptr_q] = live_src;
            q_dst_d[wr_ptr_q] = live_dest;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CntW'(accept) - CntW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            ent_src_q  <= '0;
            ent_dst_q  <= '0;
            ent_base_q <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            mk_pend_q  <= 1'b0;
            mk_addr_q  <= '0;
            mk_upper_q <= '0;
            mk_lower_q <= '0;
            q_src_q    <= '{default: '0};
            q_dst_q    <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ent_src_q  <= ent_src_d;
            ent_dst_q  <= ent_dst_d;
            ent_base_q <= ent_base_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            mk_pend_q  <= mk_pend_d;
            mk_addr_q  <= mk_addr_d;
            mk_upper_q <= mk_upper_d;
            mk_lower_q <= mk_lower_d;
            q_src_q    <= q_src_d;
            q_dst_q    <= q_dst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign log_ptr   = ptr_q;
    assign overflow  = ovf_q;
    assign live_drop = drop_q;
    assign busy      = (state_q != StIdle && state_q != StInit) | mk_pend_q | ~q_empty | cache_req;

endmodule
